// File: rtl/intr_timer_ctrl.sv
// Machine timer (64-bit mtime/mtimecmp on a word bus) plus timer/external
// interrupt arbiter that presents one held request at a time to the CSR unit.
module intr_timer_ctrl #(
  parameter int unsigned PRESCALE    = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        timer_en,
  input  logic        ext_inter,
  input  logic        bus_sel,
  input  logic        bus_wr,
  input  logic [2:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  input  logic [1:0]  irq_en,
  input  logic        irq_ack,
  input  logic        mret,
  output logic        irq_valid,
  output logic [3:0]  irq_cause,
  output logic        timer_pend
);

  localparam int unsigned PS_W        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [3:0]  CAUSE_TIMER = 4'd7;
  localparam logic [3:0]  CAUSE_EXT   = 4'd11;

  // Encoding is architecturally visible through status[3:2].
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t                 state, state_next;
  logic [3:0]             cause_q, cause_next;
  logic [63:0]            mtime, mtimecmp;
  logic [PS_W-1:0]        ps_cnt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev;
  logic                   ext_pend;
  logic [31:0]            rd_mux;

  logic wr_en, rd_en, tick, ext_rise, ext_req, tmr_req, ext_taken, status_clr;

  assign wr_en      = bus_sel & bus_wr;
  assign rd_en      = bus_sel & ~bus_wr;
  assign tick       = timer_en && (ps_cnt == PS_W'(PRESCALE - 1));
  assign ext_rise   = sync_q[SYNC_STAGES-1] & ~sync_prev;
  assign ext_req    = ext_pend & irq_en[1];
  assign tmr_req    = timer_pend & irq_en[0];
  assign ext_taken  = (state == REQ) && irq_ack && (cause_q == CAUSE_EXT);
  assign status_clr = wr_en && (bus_addr == 3'd4) && bus_wdata[0];

  // A bus write to either mtime half replaces that half and suppresses the
  // increment for the cycle, so no carry crosses into the untouched half.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst) begin
      mtime    <= '0;
      mtimecmp <= '1;
      ps_cnt   <= '0;
    end else begin
      if (timer_en) ps_cnt <= tick ? '0 : ps_cnt + PS_W'(1);
      if (wr_en && bus_addr == 3'd0)      mtime[31:0]  <= bus_wdata;
      else if (wr_en && bus_addr == 3'd1) mtime[63:32] <= bus_wdata;
      else if (tick)                      mtime        <= mtime + 64'd1;
      if (wr_en && bus_addr == 3'd2) mtimecmp[31:0]  <= bus_wdata;
      if (wr_en && bus_addr == 3'd3) mtimecmp[63:32] <= bus_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      timer_pend <= 1'b0;
      sync_q     <= '0;
      sync_prev  <= 1'b0;
      ext_pend   <= 1'b0;
    end else begin
      timer_pend <= (mtime >= mtimecmp);
      sync_q     <= {sync_q[SYNC_STAGES-2:0], ext_inter};
      sync_prev  <= sync_q[SYNC_STAGES-1];
      // A fresh edge outranks any clear arriving in the same cycle.
      if (ext_rise)                     ext_pend <= 1'b1;
      else if (status_clr || ext_taken) ext_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cause_q <= 4'd0;
    end else begin
      state   <= state_next;
      cause_q <= cause_next;
    end
  end

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned and infers a latch.
    state_next = state;
    cause_next = cause_q;
    irq_valid  = 1'b0;
    irq_cause  = 4'd0;
    unique case (state)
      IDLE: begin
        if (ext_req) begin
          state_next = REQ;
          cause_next = CAUSE_EXT;
        end else if (tmr_req) begin
          state_next = REQ;
          cause_next = CAUSE_TIMER;
        end
      end
      REQ: begin
        irq_valid = 1'b1;
        irq_cause = cause_q;
        // Acceptance wins over a source that withdraws in the same cycle.
        if (irq_ack)
          state_next = SERVICE;
        else if ((cause_q == CAUSE_EXT) ? !ext_req : !tmr_req)
          state_next = IDLE;
      end
      SERVICE: begin
        if (mret) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    unique case (bus_addr)
      3'd0:    rd_mux = mtime[31:0];
      3'd1:    rd_mux = mtime[63:32];
      3'd2:    rd_mux = mtimecmp[31:0];
      3'd3:    rd_mux = mtimecmp[63:32];
      3'd4:    rd_mux = {28'd0, state, timer_pend, ext_pend};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst)       bus_rdata <= '0;
    else if (rd_en) bus_rdata <= rd_mux;
  end

endmodule

// File: tb/tb_intr_timer_ctrl.sv
// Bench for intr_timer_ctrl: a cycle-level reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_intr_timer_ctrl;

  localparam int PRESCALE    = 1;
  localparam int SYNC_STAGES = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        timer_en = 1'b0;
  logic        ext_inter = 1'b0;
  logic        bus_sel = 1'b0;
  logic        bus_wr = 1'b0;
  logic [2:0]  bus_addr = 3'd0;
  logic [31:0] bus_wdata = 32'd0;
  logic [31:0] bus_rdata;
  logic [1:0]  irq_en = 2'b00;
  logic        irq_ack = 1'b0;
  logic        mret = 1'b0;
  logic        irq_valid;
  logic [3:0]  irq_cause;
  logic        timer_pend;

  int n_checks = 0;
  int n_errors = 0;

  intr_timer_ctrl #(.PRESCALE(PRESCALE), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst(rst), .timer_en(timer_en), .ext_inter(ext_inter),
    .bus_sel(bus_sel), .bus_wr(bus_wr), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .irq_en(irq_en),
    .irq_ack(irq_ack), .mret(mret), .irq_valid(irq_valid),
    .irq_cause(irq_cause), .timer_pend(timer_pend)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model. Arbiter position: 0 idle, 1 requesting, 2 in service.
  logic [63:0] m_mtime, m_cmp;
  int          m_phase;
  bit          m_ext_pend, m_tp;
  int          m_state, m_cause;
  logic [31:0] m_rdata;
  bit          ext_hist[$];   // sampled ext_inter, newest first
  bit          started = 1'b0;

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0:    return m_mtime[31:0];
      3'd1:    return m_mtime[63:32];
      3'd2:    return m_cmp[31:0];
      3'd3:    return m_cmp[63:32];
      3'd4:    return {28'd0, 2'(m_state), m_tp, m_ext_pend};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin : model_step
    logic [63:0] n_mtime, n_cmp;
    logic [31:0] n_rdata;
    int          n_state, n_cause, n_phase;
    bit          wr, rise, ext_req, tmr_req, took_ext, n_ext, n_tp, step;
    started = 1'b1;
    if (!rst) begin
      m_mtime = 64'd0; m_cmp = '1; m_phase = 0; m_ext_pend = 0; m_tp = 0;
      m_state = 0; m_cause = 0; m_rdata = 32'd0;
      ext_hist.delete();
      for (int k = 0; k <= SYNC_STAGES; k++) ext_hist.push_back(1'b0);
    end else begin
      wr      = bus_sel && bus_wr;
      n_rdata = (bus_sel && !bus_wr) ? model_read(bus_addr) : m_rdata;
      rise    = ext_hist[SYNC_STAGES-1] && !ext_hist[SYNC_STAGES];
      ext_hist.push_front(ext_inter);
      void'(ext_hist.pop_back());
      ext_req  = m_ext_pend && irq_en[1];
      tmr_req  = m_tp && irq_en[0];
      n_state  = m_state;
      n_cause  = m_cause;
      took_ext = 0;
      if (m_state == 0) begin
        if (ext_req)      begin n_state = 1; n_cause = 11; end
        else if (tmr_req) begin n_state = 1; n_cause = 7;  end
      end else if (m_state == 1) begin
        if (irq_ack) begin n_state = 2; took_ext = (m_cause == 11); end
        else if ((m_cause == 11) ? !ext_req : !tmr_req) n_state = 0;
      end else if (mret) begin
        n_state = 0;
      end
      if (rise) n_ext = 1;
      else if ((wr && bus_addr == 3'd4 && bus_wdata[0]) || took_ext) n_ext = 0;
      else n_ext = m_ext_pend;
      n_tp    = (m_mtime >= m_cmp);
      n_phase = m_phase;
      step    = 0;
      if (timer_en) begin
        n_phase = (m_phase + 1) % PRESCALE;
        step    = (n_phase == 0);
      end
      n_mtime = step ? m_mtime + 64'd1 : m_mtime;
      if (wr && bus_addr == 3'd0) n_mtime = {m_mtime[63:32], bus_wdata};
      if (wr && bus_addr == 3'd1) n_mtime = {bus_wdata, m_mtime[31:0]};
      n_cmp = m_cmp;
      if (wr && bus_addr == 3'd2) n_cmp[31:0]  = bus_wdata;
      if (wr && bus_addr == 3'd3) n_cmp[63:32] = bus_wdata;
      m_mtime = n_mtime; m_cmp = n_cmp; m_phase = n_phase; m_ext_pend = n_ext;
      m_tp = n_tp; m_state = n_state; m_cause = n_cause; m_rdata = n_rdata;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("model irq_valid", irq_valid, m_state == 1);
      check("model irq_cause", irq_cause, (m_state == 1) ? m_cause : 0);
      check("model timer_pend", timer_pend, m_tp);
      check("model bus_rdata", bus_rdata, m_rdata);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    bus_sel = 1'b1; bus_wr = 1'b1; bus_addr = a; bus_wdata = d;
    @(negedge clk);
    bus_sel = 1'b0; bus_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    bus_sel = 1'b1; bus_wr = 1'b0; bus_addr = a;
    @(negedge clk);
    bus_sel = 1'b0;
    d = bus_rdata;
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1; @(negedge clk); irq_ack = 1'b0;
  endtask

  task automatic pulse_mret();
    mret = 1'b1; @(negedge clk); mret = 1'b0;
  endtask

  task automatic pulse_ext();
    ext_inter = 1'b1; @(negedge clk); ext_inter = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int          waited;

    // Reset held for two edges.
    rst = 1'b0;
    cycles(2);
    check("reset irq_valid", irq_valid, 1'b0);
    check("reset irq_cause", irq_cause, 4'd0);
    check("reset timer_pend", timer_pend, 1'b0);
    check("reset bus_rdata", bus_rdata, 32'd0);
    rst = 1'b1;
    bus_read(3'd2, d); check("reset mtimecmp_lo", d, 32'hFFFF_FFFF);
    bus_read(3'd3, d); check("reset mtimecmp_hi", d, 32'hFFFF_FFFF);
    bus_read(3'd0, d); check("reset mtime_lo", d, 32'd0);

    // Timer interrupt: mtimecmp=10, count from 0.
    bus_write(3'd2, 32'd10);
    bus_write(3'd3, 32'd0);
    irq_en   = 2'b01;
    timer_en = 1'b1;
    waited   = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (timer_pend) begin waited = k; break; end
    end
    check("timer_pend rise cycle", waited, 11);
    timer_en = 1'b0;
    bus_read(3'd0, d); check("mtime at timer_pend", d, 32'd11);
    check("timer irq_valid", irq_valid, 1'b1);
    check("timer irq_cause", irq_cause, 4'd7);
    pulse_ack();
    check("timer ack drops valid", irq_valid, 1'b0);
    bus_write(3'd2, 32'hFFFF_FFFF);
    cycles(1);
    pulse_mret();
    cycles(1);
    check("timer idle after mret", irq_valid, 1'b0);

    // External interrupt through the synchroniser.
    irq_en    = 2'b10;
    ext_inter = 1'b1;
    waited    = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      ext_inter = 1'b0;
      if (irq_valid) begin waited = k; break; end
    end
    check("ext request cycle", waited, SYNC_STAGES + 2);
    check("ext irq_cause", irq_cause, 4'd11);
    bus_read(3'd4, d); check("status in REQ", d, 32'h5);
    pulse_ack();
    bus_read(3'd4, d); check("status in SERVICE", d, 32'h8);
    pulse_mret();
    bus_read(3'd4, d); check("status after mret", d, 32'h0);

    // Status write clears ext_pend; a same-cycle edge wins over the clear.
    irq_en = 2'b00;
    pulse_ext();
    cycles(3);
    bus_read(3'd4, d); check("ext_pend latched", d, 32'h1);
    bus_write(3'd4, 32'h1);
    bus_read(3'd4, d); check("ext_pend cleared", d, 32'h0);
    pulse_ext();
    cycles(1);
    bus_write(3'd4, 32'h1);
    bus_read(3'd4, d); check("edge beats clear", d, 32'h1);
    bus_write(3'd4, 32'h1);

    // Both pending: external first, then timer.
    bus_write(3'd2, 32'd5);
    pulse_ext();
    cycles(4);
    irq_en = 2'b11;
    cycles(1);
    check("both first valid", irq_valid, 1'b1);
    check("both first cause", irq_cause, 4'd11);
    pulse_ack();
    check("both ack valid", irq_valid, 1'b0);
    pulse_mret();
    check("both idle after mret", irq_valid, 1'b0);
    cycles(1);
    check("both second valid", irq_valid, 1'b1);
    check("both second cause", irq_cause, 4'd7);

    // Withdrawal: mtimecmp pushed above mtime before the ack.
    bus_write(3'd2, 32'd100);
    check("withdraw +0 valid", irq_valid, 1'b1);
    cycles(1);
    check("withdraw +1 valid", irq_valid, 1'b1);
    cycles(1);
    check("withdraw +2 valid", irq_valid, 1'b0);
    bus_read(3'd4, d); check("withdraw status", d, 32'h0);

    // mtime wrap, then write racing an increment.
    irq_en = 2'b00;
    bus_write(3'd0, 32'hFFFF_FFFF);
    bus_write(3'd1, 32'hFFFF_FFFF);
    timer_en = 1'b1;
    cycles(1);
    timer_en = 1'b0;
    bus_read(3'd0, d); check("wrap mtime_lo", d, 32'd0);
    bus_read(3'd1, d); check("wrap mtime_hi", d, 32'd0);
    bus_write(3'd0, 32'hFFFF_FFFF);
    bus_write(3'd1, 32'hFFFF_FFFF);
    timer_en = 1'b1;
    bus_write(3'd0, 32'h1234_5678);
    timer_en = 1'b0;
    bus_read(3'd0, d); check("race mtime_lo", d, 32'h1234_5678);
    bus_read(3'd1, d); check("race mtime_hi", d, 32'hFFFF_FFFF);
    bus_write(3'd5, 32'hDEAD_BEEF);
    bus_read(3'd5, d); check("unmapped read", d, 32'd0);

    // Reset in the middle of a pending request.
    irq_en = 2'b01;
    cycles(3);
    check("pre-reset valid", irq_valid, 1'b1);
    rst = 1'b0;
    cycles(1);
    check("midreset irq_valid", irq_valid, 1'b0);
    check("midreset timer_pend", timer_pend, 1'b0);
    check("midreset bus_rdata", bus_rdata, 32'd0);
    rst = 1'b1;
    bus_read(3'd3, d); check("midreset mtimecmp_hi", d, 32'hFFFF_FFFF);
    bus_read(3'd1, d); check("midreset mtime_hi", d, 32'd0);
    cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
